ring_port_arbiter: RTL and testbench
====================================

# ring_port_arbiter

Shares one outbound ring link of an Ara cluster, carrying `remote_data_t` beats to the neighbouring cluster, between `NrReq` local requesters (e.g. slide unit, reduction path, mask unit). Arbitration is round-robin at burst granularity, and a granted requester keeps the link until its whole burst has been sent. The link side is a registered valid/ready master, so the ring path starts from a flop. The block sits between the cluster's internal units and its `ring_data_{l,r}_o` port.

## Interface
- `NrReq`, default 3: number of requesters; must be ≥2.
- `DataWidth`, default 64: beat width; equals `$bits(elen_t)`.
- `MaxBurst`, default 16: maximum beats per burst; must be a power of two ≥2.
- `LenWidth`, localparam, `$clog2(MaxBurst)`: width of the burst-length field.
- `IdWidth`, localparam, `$clog2(NrReq)`: width of the grant index.

Ports:
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `req_valid_i` in [NrReq]: requester has a beat available.
- `req_data_i` in [NrReq][DataWidth]: beat payload.
- `req_len_i` in [NrReq][LenWidth]: burst length minus 1. Sampled only at grant.
- `req_ready_o` out [NrReq]: beat accepted from this requester.
- `ring_data_o` out DataWidth: link payload.
- `ring_valid_o` out 1: link beat valid.
- `ring_ready_i` in 1: neighbour accepts the beat.
- `grant_id_o` out IdWidth: current or last owner.
- `busy_o` out 1: FSM is in BURST.

## Operation
- FSM states: IDLE and BURST. Registers: `owner_q`, `rem_q` (LenWidth), `ptr_q` (last served index), and the output stage `valid_q`/`data_q`.
- IDLE:
  - If any `req_valid_i` is set, the winner is the first valid index scanning `ptr_q+1, ptr_q+2, …` modulo `NrReq`.
  - Load `owner_q`=winner and `rem_q`=`req_len_i[winner]`, then go to BURST.
  - No beat is accepted in IDLE. All `req_ready_o` are 0.
- BURST:
  - Let `out_free` = `!valid_q || ring_ready_i`.
  - `req_ready_o[owner_q]` = `out_free`; all other bits are 0.
  - A beat transfers when `req_valid_i[owner_q] && out_free`. On transfer, `data_q` ← `req_data_i[owner_q]` and `valid_q` ← 1.
  - On a transfer with `rem_q`==0: `ptr_q` ← `owner_q`, go to IDLE. Otherwise `rem_q` decrements by 1.
  - If the owner drops valid mid-burst, the lock holds. The FSM waits in BURST indefinitely and no other requester is served.
- Output stage:
  - `valid_q` clears when `ring_ready_i` is high and no new beat is loaded that cycle.
  - Load and drain in the same cycle gives full throughput: one beat per cycle under continuous ready.
  - `ring_data_o` = `data_q` and `ring_valid_o` = `valid_q`. Once `ring_valid_o` rises, the data stays stable until `ring_ready_i`.
- `grant_id_o` = `owner_q`; `busy_o` = (state==BURST).
- Requesters must follow AXI-stream rules: no combinational path from `req_ready_o` to `req_valid_i`.

## Timing
- Reset values: state=IDLE, `ptr_q`=`NrReq-1` (so index 0 wins first), `owner_q`=0, `rem_q`=0, `valid_q`=0, `data_q`=0.
  - Therefore `ring_valid_o`=0, `ring_data_o`=0, `req_ready_o`=0, `grant_id_o`=0, `busy_o`=0.
- Reset asserted mid-burst: all state returns to reset values at the next edge, and any beat held in the output register is dropped.
- Latency: `req_valid_i` seen in IDLE at cycle 0 → grant, first `req_ready_o` at cycle 1 → `ring_valid_o` at cycle 2.
- A burst of N beats under full ready occupies N+1 cycles, because of the one IDLE bubble between bursts.
- Simultaneous events:
  - Last beat accepted and output drain in the same cycle: both happen.
  - If a new request is pending, the new grant occurs in the following IDLE cycle.
- `ring_ready_i` low with `valid_q`=1: `req_ready_o` stays 0 and the beat is held.
- `rem_q` never wraps, since the FSM leaves BURST when `rem_q` is 0.

## Test plan
- Single beat: req0 valid, len=0, data=0xA5, `ring_ready_i`=1 → `req_ready_o[0]` high at cycle 1, `ring_valid_o`/`ring_data_o`=0xA5 at cycle 2, `busy_o` back to 0 at cycle 2.
- Full burst: req1 len=3, data 1..4, ready high → four consecutive beats 1,2,3,4 on the ring at cycles 2–5, `grant_id_o`=1.
- Round-robin: all three requesters valid with len=1 after reset → bursts serviced in order 0,1,2,0. Each burst is two beats, with one IDLE bubble between bursts.
- Backpressure: req0 len=3, `ring_ready_i` low during cycles 3–5 → the beat on the ring is held stable, `req_ready_o[0]`=0 during the stall, and no beat is lost or duplicated.
- Lock hold: req0 len=3 drops valid after 2 beats while req2 is valid → req2 is never granted until req0 delivers its remaining 2 beats.
- Reset mid-burst: `rst_i` pulsed after beat 2 of 4 → next cycle all outputs at reset values. Afterwards a new req2 len=0 is granted, with index 0 priority restored.

Source files
------------

// File: rtl/ring_port_arbiter.sv
// ring_port_arbiter: burst-granular round-robin arbiter feeding a registered valid/ready ring link
module ring_port_arbiter #(
  parameter int NrReq = 3,
  parameter int DataWidth = 64,
  parameter int MaxBurst = 16,
  localparam int LenWidth = $clog2(MaxBurst),
  localparam int IdWidth = $clog2(NrReq)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NrReq-1:0]                   req_valid_i,
  input  logic [NrReq-1:0][DataWidth-1:0]    req_data_i,
  input  logic [NrReq-1:0][LenWidth-1:0]     req_len_i,
  output logic [NrReq-1:0]                   req_ready_o,
  output logic [DataWidth-1:0]               ring_data_o,
  output logic                               ring_valid_o,
  input  logic                               ring_ready_i,
  output logic [IdWidth-1:0]                 grant_id_o,
  output logic                               busy_o
);
  typedef enum logic {IDLE, BURST} state_e;
  state_e state_q, state_d;
  logic [IdWidth-1:0] owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic valid_q, valid_d, out_free, xfer;
  logic [DataWidth-1:0] data_q, data_d;
  always_comb begin
    winner = owner_q;
    for (int i = NrReq; i >= 1; i--)
      if (req_valid_i[(int'(ptr_q) + i) % NrReq]) winner = IdWidth'((int'(ptr_q) + i) % NrReq);
  end
  always_comb begin
    out_free = !valid_q || ring_ready_i;
    xfer = state_q == BURST && req_valid_i[owner_q] && out_free;
    state_d = state_q;
    owner_d = owner_q;
    rem_d = rem_q;
    ptr_d = ptr_q;
    valid_d = valid_q && !ring_ready_i;
    data_d = data_q;
    req_ready_o = '0;
    if (state_q == IDLE && |req_valid_i) begin
      state_d = BURST;
      owner_d = winner;
      rem_d = req_len_i[winner];
    end
    if (state_q == BURST) req_ready_o[owner_q] = out_free;
    if (xfer) begin
      data_d = req_data_i[owner_q];
      valid_d = 1'b1;
      ptr_d = rem_q == '0 ? owner_q : ptr_q;
      state_d = rem_q == '0 ? IDLE : BURST;
      rem_d = rem_q == '0 ? rem_q : rem_q - 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= IdWidth'(NrReq - 1);
      rem_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign ring_data_o = data_q;
  assign ring_valid_o = valid_q;
  assign grant_id_o = owner_q;
  assign busy_o = state_q == BURST;
endmodule

// File: tb/tb_ring_port_arbiter.sv
// tb_ring_port_arbiter: scoreboard bench with a burst-level round-robin reference model
module tb_ring_port_arbiter;
  localparam int NR = 3, DW = 64, MB = 16, LW = $clog2(MB), IW = $clog2(NR);
  logic clk = 1'b0, rst_i = 1'b1;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0][DW-1:0] req_data_i = '0;
  logic [NR-1:0][LW-1:0] req_len_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [DW-1:0] ring_data_o;
  logic ring_valid_o, busy_o;
  logic ring_ready_i = 1'b1;
  logic [IW-1:0] grant_id_o;
  int n_chk = 0, n_fail = 0, last = NR - 1, tcnt = 0;
  int hold [NR];
  bit started [NR];
  bit gaps = 0, rnd_rdy = 0, bp = 0;
  logic [DW-1:0] pend [NR][$];
  logic [DW-1:0] exp_q [$];
  logic pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;

  always #5 clk = ~clk;

  ring_port_arbiter #(.NrReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_len_i(req_len_i), .req_ready_o(req_ready_o), .ring_data_o(ring_data_o),
    .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i), .grant_id_o(grant_id_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (pv && !pr) begin
        chk("hold_valid", DW'(ring_valid_o), 64'd1);
        chk("hold_data", ring_data_o, pd);
      end
      if (ring_valid_o && !ring_ready_i) chk("stall_ready", DW'(req_ready_o), 64'd0);
      if (ring_valid_o && ring_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_beat: got %0h expected no beat", ring_data_o);
        end else chk("beat", ring_data_o, exp_q.pop_front());
      end
    end
    pv <= ring_valid_o && !rst_i;
    pr <= ring_ready_i;
    pd <= ring_data_o;
  end

  task automatic cyc();
    logic [NR-1:0] fire;
    @(negedge clk);
    fire = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    tcnt++;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        void'(pend[i].pop_front());
        started[i] = 1;
      end
      if (pend[i].size() == 0) started[i] = 0;
      if (hold[i] > 0) hold[i]--;
      req_valid_i[i] = pend[i].size() > 0 && hold[i] == 0 && (!started[i] || !gaps || $urandom_range(3) != 0);
      req_data_i[i] = pend[i].size() > 0 ? pend[i][0] : '0;
    end
    ring_ready_i = bp ? !(tcnt >= 3 && tcnt <= 5) : (!rnd_rdy || $urandom_range(3) != 0);
    #1;
  endtask

  task automatic issue(input logic [NR-1:0] mask, input int len, input logic [DW-1:0] d0);
    logic [DW-1:0] d;
    int nl;
    d = d0;
    nl = last;
    for (int k = 1; k <= NR; k++) begin
      int i, n;
      i = (last + k) % NR;
      if (mask[i]) begin
        n = len < 0 ? int'($urandom_range(MB - 1)) : len;
        req_len_i[i] = LW'(n);
        for (int b = 0; b <= n; b++) begin
          pend[i].push_back(d);
          exp_q.push_back(d);
          d++;
        end
        req_valid_i[i] = 1'b1;
        req_data_i[i] = pend[i][0];
        nl = i;
      end
    end
    last = nl;
  endtask

  task automatic drain(input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget && (exp_q.size() > 0 || busy_o || |req_valid_i)) begin
      cyc();
      cnt++;
    end
    chk("drained", DW'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i].delete();
      hold[i] = 0;
      started[i] = 0;
    end
    req_valid_i = '0;
    exp_q.delete();
    cyc();
    rst_i = 1'b0;
    last = NR - 1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, DW'(ring_valid_o), 64'd0);
    chk({tag, "_data"}, ring_data_o, 64'd0);
    chk({tag, "_ready"}, DW'(req_ready_o), 64'd0);
    chk({tag, "_grant"}, DW'(grant_id_o), 64'd0);
    chk({tag, "_busy"}, DW'(busy_o), 64'd0);
  endtask

  initial begin
    int c;
    do_reset();
    chk_reset("rst");
    issue(3'b001, 0, 64'hA5);
    cyc();
    chk("single_ready", DW'(req_ready_o), 64'd1);
    cyc();
    chk("single_valid", DW'(ring_valid_o), 64'd1);
    chk("single_data", ring_data_o, 64'hA5);
    chk("single_busy", DW'(busy_o), 64'd0);
    drain(50, c);
    issue(3'b010, 3, 64'd1);
    drain(100, c);
    chk("burst_cycles", DW'(c), 64'd6);
    chk("burst_grant", DW'(grant_id_o), 64'd1);
    do_reset();
    issue(3'b111, 1, 64'h10);
    drain(100, c);
    chk("rr_cycles", DW'(c), 64'd10);
    issue(3'b001, 1, 64'h20);
    drain(100, c);
    chk("rr_grant", DW'(grant_id_o), 64'd0);
    issue(3'b001, 3, 64'h30);
    tcnt = 0;
    bp = 1;
    drain(100, c);
    bp = 0;
    chk("bp_cycles", DW'(c), 64'd9);
    issue(3'b001, 3, 64'h300);
    for (int k = 0; k < 20 && pend[0].size() > 2; k++) cyc();
    do_reset();
    chk_reset("midrst");
    issue(3'b101, 0, 64'h500);
    drain(100, c);
    chk("postrst_grant", DW'(grant_id_o), 64'd2);
    issue(3'b101, 3, 64'h700);
    for (int k = 0; k < 20 && pend[0].size() > 2; k++) cyc();
    hold[0] = 5;
    req_valid_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("lock_busy", DW'(busy_o), 64'd1);
      chk("lock_grant", DW'(grant_id_o), 64'd0);
      chk("lock_ready2", DW'(req_ready_o[2]), 64'd0);
    end
    drain(100, c);
    gaps = 1;
    rnd_rdy = 1;
    for (int r = 0; r < 30; r++) begin
      issue(NR'($urandom_range(1, 7)), -1, {$urandom, $urandom});
      drain(2000, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
